// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: runs one decoded instruction at a time, sequencing
// LD/ST buffer-memory beats, the GEMM compute window and the DRAINSYS window.
module inst_dispatcher #(
   parameter int OPCODE_WIDTH  = 4,
   parameter int BUF_ID_WIDTH  = 2,
   parameter int MEM_LOC_WIDTH = 10,
   parameter int TILE_ROWS     = 8,
   parameter int GEMM_CYCLES   = 16,
   parameter int DRAIN_CYCLES  = 8,
   parameter logic [OPCODE_WIDTH-1:0] opcode_LD       = 4'b0010,
   parameter logic [OPCODE_WIDTH-1:0] opcode_ST       = 4'b0011,
   parameter logic [OPCODE_WIDTH-1:0] opcode_GEMM     = 4'b0100,
   parameter logic [OPCODE_WIDTH-1:0] opcode_DRAINSYS = 4'b0101
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          inst_valid,
   output logic                          inst_ready,
   input  logic [OPCODE_WIDTH-1:0]       opcode,
   input  logic [BUF_ID_WIDTH-1:0]       buf_id,
   input  logic [MEM_LOC_WIDTH-1:0]      mem_loc,
   output logic                          mem_valid,
   input  logic                          mem_ready,
   output logic                          mem_we,
   output logic [MEM_LOC_WIDTH-1:0]      mem_addr,
   output logic [BUF_ID_WIDTH-1:0]       buf_sel,
   output logic [$clog2(TILE_ROWS)-1:0]  buf_row,
   output logic                          sa_en,
   output logic                          sa_drain,
   output logic                          busy,
   output logic                          illegal_op,
   output logic [15:0]                   retired_count
);

   localparam int ROW_W   = $clog2(TILE_ROWS);
   localparam int MAX_CYC = (GEMM_CYCLES > DRAIN_CYCLES) ? GEMM_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(TILE_ROWS - 1);
   localparam logic [CNT_W-1:0] GEMM_LAST  = CNT_W'(GEMM_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, XFER, GEMM, DRAIN} state_t;

   state_t                     state, state_nxt;
   logic [ROW_W-1:0]           row, row_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic [MEM_LOC_WIDTH-1:0]   base_q;
   logic [BUF_ID_WIDTH-1:0]    bsel_q;
   logic                       we_q;
   logic                       take, illegal_nxt, retire;

   always_comb begin
      state_nxt   = state;
      row_nxt     = row;
      cnt_nxt     = cnt;
      take        = 1'b0;
      illegal_nxt = 1'b0;
      retire      = 1'b0;
      mem_valid   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      buf_sel     = '0;
      buf_row     = '0;
      sa_en       = 1'b0;
      sa_drain    = 1'b0;
      inst_ready  = (state == IDLE);
      busy        = (state != IDLE);

      case (state)
         IDLE: begin
            if (inst_valid) begin
               if (opcode == opcode_LD || opcode == opcode_ST) begin
                  take      = 1'b1;
                  state_nxt = XFER;
                  row_nxt   = '0;
               end else if (opcode == opcode_GEMM) begin
                  take      = 1'b1;
                  state_nxt = GEMM;
                  cnt_nxt   = '0;
               end else if (opcode == opcode_DRAINSYS) begin
                  take      = 1'b1;
                  state_nxt = DRAIN;
                  cnt_nxt   = '0;
               end else begin
                  illegal_nxt = 1'b1;
               end
            end
         end
         XFER: begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_q + MEM_LOC_WIDTH'(row);
            buf_sel   = bsel_q;
            buf_row   = row;
            if (mem_ready) begin
               if (row == LAST_ROW) begin
                  state_nxt = IDLE;
                  retire    = 1'b1;
                  row_nxt   = '0;
               end else begin
                  row_nxt = row + 1'b1;
               end
            end
         end
         GEMM: begin
            sa_en = 1'b1;
            if (cnt == GEMM_LAST) begin
               state_nxt = IDLE;
               retire    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DRAIN: begin
            sa_drain = 1'b1;
            if (cnt == DRAIN_LAST) begin
               state_nxt = IDLE;
               retire    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         row           <= '0;
         cnt           <= '0;
         base_q        <= '0;
         bsel_q        <= '0;
         we_q          <= 1'b0;
         illegal_op    <= 1'b0;
         retired_count <= '0;
      end else begin
         state      <= state_nxt;
         row        <= row_nxt;
         cnt        <= cnt_nxt;
         illegal_op <= illegal_nxt;
         if (take) begin
            base_q <= mem_loc;
            bsel_q <= buf_id;
            we_q   <= (opcode == opcode_ST);
         end
         if (retire)
            retired_count <= retired_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed self-checking bench for inst_dispatcher with hand-computed expectations.
module tb_inst_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  opcode;
   logic [1:0]  buf_id;
   logic [9:0]  mem_loc;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [1:0]  buf_sel;
   logic [2:0]  buf_row;
   logic        sa_en;
   logic        sa_drain;
   logic        busy;
   logic        illegal_op;
   logic [15:0] retired_count;

   int total = 0;
   int bad   = 0;
   int beats = 0;
   int overlap = 0;
   int beats_before;

   logic [9:0] st_addr [8] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001,
                               10'h002, 10'h003, 10'h004, 10'h005};

   always #5 clk = ~clk;

   inst_dispatcher #(
      .OPCODE_WIDTH(4), .BUF_ID_WIDTH(2), .MEM_LOC_WIDTH(10),
      .TILE_ROWS(8), .GEMM_CYCLES(16), .DRAIN_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .opcode(opcode), .buf_id(buf_id), .mem_loc(mem_loc),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .buf_sel(buf_sel), .buf_row(buf_row),
      .sa_en(sa_en), .sa_drain(sa_drain), .busy(busy),
      .illegal_op(illegal_op), .retired_count(retired_count)
   );

   always @(posedge clk)
      if (mem_valid && mem_ready) beats <= beats + 1;

   always @(negedge clk)
      if ($countones({mem_valid, sa_en, sa_drain}) > 1) overlap <= overlap + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic [15:0] exp_ret);
      check({tag, ".inst_ready"}, 32'(inst_ready), 32'd1);
      check({tag, ".busy"},       32'(busy),       32'd0);
      check({tag, ".mem_valid"},  32'(mem_valid),  32'd0);
      check({tag, ".mem_we"},     32'(mem_we),     32'd0);
      check({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
      check({tag, ".buf_sel"},    32'(buf_sel),    32'd0);
      check({tag, ".buf_row"},    32'(buf_row),    32'd0);
      check({tag, ".sa_en"},      32'(sa_en),      32'd0);
      check({tag, ".sa_drain"},   32'(sa_drain),   32'd0);
      check({tag, ".illegal_op"}, 32'(illegal_op), 32'd0);
      check({tag, ".retired"},    32'(retired_count), 32'(exp_ret));
   endtask

   initial begin
      rst = 1'b1; inst_valid = 1'b0; opcode = '0; buf_id = '0; mem_loc = '0; mem_ready = 1'b0;
      tick();
      tick();
      check_idle("reset", 16'd0);
      rst = 1'b0;
      tick();
      check_idle("post_reset", 16'd0);

      // Abort an LD at beat 4 with reset
      inst_valid = 1'b1; opcode = 4'b0010; buf_id = 2'd1; mem_loc = 10'h020; mem_ready = 1'b1;
      tick();
      inst_valid = 1'b0;
      check("abort.beat0_valid", 32'(mem_valid), 32'd1);
      repeat (4) tick();
      check("abort.beat4_row",  32'(buf_row),  32'd4);
      check("abort.beat4_addr", 32'(mem_addr), 32'h024);
      rst = 1'b1;
      tick();
      check_idle("abort", 16'd0);
      rst = 1'b0;
      tick();

      // Fresh LD, fields scrambled while busy with inst_valid still high
      inst_valid = 1'b1; opcode = 4'b0010; buf_id = 2'd1; mem_loc = 10'h010; mem_ready = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ld.valid%0d", i), 32'(mem_valid),  32'd1);
         check($sformatf("ld.row%0d", i),   32'(buf_row),    32'(i));
         check($sformatf("ld.addr%0d", i),  32'(mem_addr),   32'h010 + 32'(i));
         check($sformatf("ld.sel%0d", i),   32'(buf_sel),    32'd1);
         check($sformatf("ld.we%0d", i),    32'(mem_we),     32'd0);
         check($sformatf("ld.ready%0d", i), 32'(inst_ready), 32'd0);
         opcode = 4'b0011; buf_id = 2'(i); mem_loc = 10'h155 + 10'(i);
         if (i == 7) inst_valid = 1'b0;
         tick();
      end
      check_idle("ld_done", 16'd1);

      // ST with wrapping address and stalled beats
      inst_valid = 1'b1; opcode = 4'b0011; buf_id = 2'd2; mem_loc = 10'h3FE; mem_ready = 1'b0;
      beats_before = beats;
      tick();
      inst_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
         mem_ready = 1'b0;
         for (int s = 0; s < 2; s++) begin
            check($sformatf("st.valid%0d_%0d", b, s), 32'(mem_valid), 32'd1);
            check($sformatf("st.addr%0d_%0d", b, s),  32'(mem_addr),  32'(st_addr[b]));
            check($sformatf("st.row%0d_%0d", b, s),   32'(buf_row),   32'(b));
            check($sformatf("st.sel%0d_%0d", b, s),   32'(buf_sel),   32'd2);
            check($sformatf("st.we%0d_%0d", b, s),    32'(mem_we),    32'd1);
            if (s == 0) tick();
         end
         mem_ready = 1'b1;
         tick();
      end
      mem_ready = 1'b0;
      check("st.beats", 32'(beats - beats_before), 32'd8);
      check_idle("st_done", 16'd2);

      // GEMM then DRAINSYS held back-to-back
      inst_valid = 1'b1; opcode = 4'b0100; buf_id = 2'd0; mem_loc = 10'h000;
      tick();
      opcode = 4'b0101;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("gemm.en%0d", i),    32'(sa_en),      32'd1);
         check($sformatf("gemm.drain%0d", i), 32'(sa_drain),   32'd0);
         check($sformatf("gemm.ready%0d", i), 32'(inst_ready), 32'd0);
         tick();
      end
      check_idle("gap", 16'd3);
      tick();
      inst_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain.drain%0d", i), 32'(sa_drain), 32'd1);
         check($sformatf("drain.en%0d", i),    32'(sa_en),    32'd0);
         check($sformatf("drain.busy%0d", i),  32'(busy),     32'd1);
         tick();
      end
      check_idle("drain_done", 16'd4);

      // Illegal opcode, then a GEMM accepted in the very next cycle
      inst_valid = 1'b1; opcode = 4'b1111;
      tick();
      check("ill.pulse",     32'(illegal_op),    32'd1);
      check("ill.ready",     32'(inst_ready),    32'd1);
      check("ill.mem_valid", 32'(mem_valid),     32'd0);
      check("ill.sa_en",     32'(sa_en),         32'd0);
      check("ill.sa_drain",  32'(sa_drain),      32'd0);
      check("ill.retired",   32'(retired_count), 32'd4);
      opcode = 4'b0100;
      tick();
      inst_valid = 1'b0;
      check("ill.pulse_end", 32'(illegal_op), 32'd0);
      check("ill.next_gemm", 32'(sa_en),      32'd1);
      repeat (16) tick();
      check_idle("final", 16'd5);

      check("no_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_dispatcher.md
# inst_dispatcher

Executes decoded instructions from the instruction reader, one at a time. It sequences the memory/buffer transfers for LD/ST, the systolic-array compute window for GEMM and the drain window for DRAINSYS. It sits directly downstream of the instruction reader, upstream of the buffer/memory port and the systolic-array control inputs. A valid/ready handshake on its input stalls the reader while an instruction is in flight.

## Interface
Parameters:
- OPCODE_WIDTH, 4, opcode field width
- BUF_ID_WIDTH, 2, buffer id width
- MEM_LOC_WIDTH, 10, memory address width
- TILE_ROWS, 8, rows moved per LD/ST (power of two, ≥2)
- GEMM_CYCLES, 16, cycles sa_en is held per GEMM (≥1)
- DRAIN_CYCLES, 8, cycles sa_drain is held per DRAINSYS (≥1)
- opcode_LD / opcode_ST / opcode_GEMM / opcode_DRAINSYS, 4'b0010 / 4'b0011 / 4'b0100 / 4'b0101

Ports:
- clk  in  1  clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  instruction fields valid
- inst_ready  out  1  dispatcher can accept an instruction
- opcode  in  OPCODE_WIDTH  instruction opcode
- buf_id  in  BUF_ID_WIDTH  target buffer
- mem_loc  in  MEM_LOC_WIDTH  base memory address
- mem_valid  out  1  transfer beat request
- mem_ready  in  1  beat accepted by memory/buffer side
- mem_we  out  1  1 = ST (buffer→memory), 0 = LD (memory→buffer)
- mem_addr  out  MEM_LOC_WIDTH  beat memory address
- buf_sel  out  BUF_ID_WIDTH  buffer for current beat
- buf_row  out  $clog2(TILE_ROWS)  buffer row for current beat
- sa_en  out  1  systolic array compute enable
- sa_drain  out  1  systolic array drain enable
- busy  out  1  instruction in flight
- illegal_op  out  1  one-cycle pulse: unknown opcode dropped
- retired_count  out  16  instructions completed, wraps at 2^16

## Operation
- States: IDLE, XFER, GEMM, DRAIN.
- inst_ready = (state == IDLE). busy = !IDLE.
- Handshake occurs when inst_valid && inst_ready. On it, opcode, buf_id and mem_loc are latched. Inputs are ignored at all other times.
- On a handshake, IDLE moves to:
  - XFER for LD/ST: mem_we = (opcode == opcode_ST); row counter cleared.
  - GEMM: cycle counter cleared.
  - DRAIN: cycle counter cleared.
  - Any other opcode: stays IDLE, illegal_op pulses for one cycle next cycle, and the instruction is not retired.
- XFER behaviour:
  - mem_valid = 1, buf_sel = latched buf_id, buf_row = row, mem_addr = (base + row) mod 2^MEM_LOC_WIDTH. The address wraps silently.
  - A beat completes on mem_valid && mem_ready, and row increments.
  - Without mem_ready, all beat outputs hold stable.
  - After beat TILE_ROWS−1 completes, the state goes to IDLE.
- GEMM: sa_en = 1 for exactly GEMM_CYCLES cycles, then IDLE.
- DRAIN: sa_drain = 1 for exactly DRAIN_CYCLES cycles, then IDLE.
- Outside their states, mem_valid, sa_en and sa_drain are 0. mem_addr, buf_sel, buf_row and mem_we are 0 outside XFER.
- retired_count increments on the edge where XFER, GEMM or DRAIN returns to IDLE.
- At most one of mem_valid, sa_en, sa_drain is 1 in any cycle.

## Timing
- Reset: state IDLE, counters 0. During reset and in the first cycle after it, every output is 0 except inst_ready = 1.
- Reset mid-instruction aborts it. The instruction is not retired, and the outputs above hold from the next cycle.
- Handshake at edge N: the first mem_valid, sa_en or sa_drain cycle is the cycle following edge N (1-cycle latency).
- XFER with mem_ready held high: TILE_ROWS cycles of mem_valid. inst_ready is high in the cycle after the last beat.
- Back-to-back instructions: a new handshake is possible in the first IDLE cycle, giving exactly one IDLE cycle between instructions.
- Illegal opcode: handshake at edge N, illegal_op high during cycle N+1, inst_ready remains 1 throughout.
- retired_count wraps 0xFFFF→0x0000.

## Test plan
- Reset, then LD buf_id=1 mem_loc=0x010 with mem_ready=1 → 8 beats, mem_addr 0x010..0x017, buf_row 0..7, buf_sel=1, mem_we=0; retired_count=1.
- ST buf_id=2 mem_loc=0x3FE, mem_ready toggling 1/0 → mem_addr 0x3FE, 0x3FF, 0x000..0x005 with wrap; outputs stable while mem_ready=0; mem_we=1; exactly 8 accepted beats.
- GEMM then DRAINSYS presented back-to-back → sa_en high exactly 16 cycles, one IDLE cycle, sa_drain high exactly 8 cycles; never overlapping; retired_count +2.
- Opcode 4'b1111 → illegal_op one-cycle pulse, no mem_valid/sa_en/sa_drain, retired_count unchanged, next valid instruction accepted immediately.
- rst asserted during beat 4 of an LD → next cycle all outputs 0, inst_ready=1, retired_count unchanged; a fresh LD then completes all 8 beats from row 0.
- inst_valid held high while busy with changing fields → only fields present at the handshake are used; inst_ready=0 for the whole instruction.
